// File: rtl/usrt_pkg.sv
// Shared USRT constants and helpers used by the receive FIFO and the UART-side blocks.
package usrt_pkg;

  localparam int RX_FIFO_DEPTH_DEFAULT = 4;
  localparam int USRT_CHAR_WIDTH       = 8;

  // Occupancy counter must encode 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rxfifo_if.sv
// Receive FIFO port bundle: deserialiser write side plus register-side read and status.
interface rxfifo_if import usrt_pkg::*; #(
  parameter int DATA_WIDTH = USRT_CHAR_WIDTH,
  parameter int DEPTH      = RX_FIFO_DEPTH_DEFAULT
);

  logic                            i_Push;
  logic [DATA_WIDTH-1:0]           i_Data;
  logic                            i_Pop;
  logic                            i_ClrOvr;
  logic [DATA_WIDTH-1:0]           o_Data;
  logic                            o_Empty;
  logic                            o_Full;
  logic                            o_AlmostFull;
  logic [count_width(DEPTH)-1:0]   o_Count;
  logic                            o_Overrun;

  modport master (
    output i_Push, i_Data, i_Pop, i_ClrOvr,
    input  o_Data, o_Empty, o_Full, o_AlmostFull, o_Count, o_Overrun
  );

  modport slave (
    input  i_Push, i_Data, i_Pop, i_ClrOvr,
    output o_Data, o_Empty, o_Full, o_AlmostFull, o_Count, o_Overrun
  );

endinterface

// File: rtl/rxfifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read, no reset.
module rxfifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       i_Pclk,
  input  logic                       i_WrEn,
  input  logic [$clog2(DEPTH)-1:0]   i_WrAddr,
  input  logic [DATA_WIDTH-1:0]      i_WrData,
  input  logic [$clog2(DEPTH)-1:0]   i_RdAddr,
  output logic [DATA_WIDTH-1:0]      o_RdData
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_Pclk) begin
    if (i_WrEn) mem[i_WrAddr] <= i_WrData;
  end

  assign o_RdData = mem[i_RdAddr];

endmodule

// File: rtl/rxfifo.sv
// Receive FIFO for the USRT Rx path: first-word-fall-through read, counter-derived flags, sticky overrun.
module rxfifo import usrt_pkg::*; #(
  parameter int DATA_WIDTH  = USRT_CHAR_WIDTH,
  parameter int DEPTH       = RX_FIFO_DEPTH_DEFAULT,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic    i_Pclk,
  input  logic    i_Reset_n,
  rxfifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          pop_ok;
  logic          push_ok;
  logic          push_drop;

  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign pop_ok    = bus.i_Pop && (count != '0);
  assign push_ok   = bus.i_Push && ((count != CW'(DEPTH)) || pop_ok);
  assign push_drop = bus.i_Push && !push_ok;

  always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_drop)         overrun <= 1'b1;
      else if (bus.i_ClrOvr) overrun <= 1'b0;
    end
  end

  rxfifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .i_Pclk   (i_Pclk),
    .i_WrEn   (push_ok),
    .i_WrAddr (wr_ptr),
    .i_WrData (bus.i_Data),
    .i_RdAddr (rd_ptr),
    .o_RdData (bus.o_Data)
  );

  assign bus.o_Empty      = (count == '0);
  assign bus.o_Full       = (count == CW'(DEPTH));
  assign bus.o_AlmostFull = (count >= CW'(AFULL_LEVEL));
  assign bus.o_Count      = count;
  assign bus.o_Overrun    = overrun;

endmodule

// File: tb/tb_rxfifo.sv
// Drives three rxfifo configurations in lockstep and compares each against a queue-based model.
module tb_rxfifo;

  logic clk;
  logic rst_n;

  rxfifo_if #(.DATA_WIDTH(8), .DEPTH(4))  if0 ();
  rxfifo_if #(.DATA_WIDTH(9), .DEPTH(2))  if1 ();
  rxfifo_if #(.DATA_WIDTH(9), .DEPTH(16)) if2 ();

  rxfifo #(.DATA_WIDTH(8), .DEPTH(4)) u_dut0 (
    .i_Pclk(clk), .i_Reset_n(rst_n), .bus(if0)
  );
  rxfifo #(.DATA_WIDTH(9), .DEPTH(2)) u_dut1 (
    .i_Pclk(clk), .i_Reset_n(rst_n), .bus(if1)
  );
  rxfifo #(.DATA_WIDTH(9), .DEPTH(16), .AFULL_LEVEL(12)) u_dut2 (
    .i_Pclk(clk), .i_Reset_n(rst_n), .bus(if2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int       depth_k [3] = '{4, 2, 16};
  int       af_k    [3] = '{3, 1, 12};
  logic [8:0] mask_k [3] = '{9'h0FF, 9'h1FF, 9'h1FF};
  logic [8:0] q     [3][$];
  bit         ovr_m [3];

  logic [4:0] obs_cnt  [3];
  logic [8:0] obs_data [3];
  logic [3:0] obs_flag [3];

  assign obs_cnt[0]  = {2'b00, if0.o_Count};
  assign obs_cnt[1]  = {3'b000, if1.o_Count};
  assign obs_cnt[2]  = if2.o_Count;
  assign obs_data[0] = {1'b0, if0.o_Data};
  assign obs_data[1] = if1.o_Data;
  assign obs_data[2] = if2.o_Data;
  assign obs_flag[0] = {if0.o_Empty, if0.o_Full, if0.o_AlmostFull, if0.o_Overrun};
  assign obs_flag[1] = {if1.o_Empty, if1.o_Full, if1.o_AlmostFull, if1.o_Overrun};
  assign obs_flag[2] = {if2.o_Empty, if2.o_Full, if2.o_AlmostFull, if2.o_Overrun};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      int c;
      c = q[k].size();
      chk({tag, "_count"}, k, 32'(obs_cnt[k]), 32'(c));
      chk({tag, "_empty"}, k, 32'(obs_flag[k][3]), 32'(c == 0));
      chk({tag, "_full"},  k, 32'(obs_flag[k][2]), 32'(c == depth_k[k]));
      chk({tag, "_afull"}, k, 32'(obs_flag[k][1]), 32'(c >= af_k[k]));
      chk({tag, "_ovr"},   k, 32'(obs_flag[k][0]), 32'(ovr_m[k]));
      if (c != 0) chk({tag, "_data"}, k, 32'(obs_data[k]), 32'(q[k][0]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      q[k].delete();
      ovr_m[k] = 1'b0;
    end
  endtask

  task automatic step(input string tag, input bit push, input logic [8:0] d, input bit pop, input bit clr);
    if0.i_Push = push; if0.i_Data = d[7:0]; if0.i_Pop = pop; if0.i_ClrOvr = clr;
    if1.i_Push = push; if1.i_Data = d;      if1.i_Pop = pop; if1.i_ClrOvr = clr;
    if2.i_Push = push; if2.i_Data = d;      if2.i_Pop = pop; if2.i_ClrOvr = clr;
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      int  c;
      bit  pop_ok;
      bit  push_ok;
      c       = q[k].size();
      pop_ok  = pop && (c > 0);
      push_ok = push && ((c < depth_k[k]) || pop_ok);
      if (push && !push_ok) ovr_m[k] = 1'b1;
      else if (clr)         ovr_m[k] = 1'b0;
      if (pop_ok)  void'(q[k].pop_front());
      if (push_ok) q[k].push_back(d & mask_k[k]);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [8:0] vals [4];
    vals = '{9'h011, 9'h022, 9'h033, 9'h044};
    if0.i_Push = 0; if0.i_Data = 0; if0.i_Pop = 0; if0.i_ClrOvr = 0;
    if1.i_Push = 0; if1.i_Data = 0; if1.i_Pop = 0; if1.i_ClrOvr = 0;
    if2.i_Push = 0; if2.i_Data = 0; if2.i_Pop = 0; if2.i_ClrOvr = 0;
    rst_n = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_all("rst_async");
    @(negedge clk) rst_n = 1'b1;

    step("pop_empty", 0, 9'h000, 1, 0);

    for (int i = 0; i < 4; i++) step("fill", 1, vals[i], 0, 0);
    step("ovr_push", 1, 9'h055, 0, 0);
    step("clr_alone", 0, 9'h000, 0, 1);
    step("ovr_set", 1, 9'h055, 0, 0);
    step("clr_drop", 1, 9'h056, 0, 1);
    step("clr_again", 0, 9'h000, 0, 1);
    step("full_pushpop", 1, 9'h066, 1, 0);
    for (int i = 0; i < 4; i++) step("drain", 0, 9'h000, 1, 0);
    step("empty_pushpop", 1, 9'h077, 1, 0);
    step("pop77", 0, 9'h000, 1, 0);

    step("wrap", 1, 9'h000, 0, 0);
    for (int i = 1; i < 10; i++) step("wrap", 1, 9'(i), 1, 0);
    step("wrap_end", 0, 9'h000, 1, 0);

    for (int i = 0; i < 3; i++) step("pre_rst", 1, 9'(8'hA0 + i), 0, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    @(negedge clk) rst_n = 1'b1;

    step("w9_push", 1, 9'h1FF, 0, 0);
    step("w9_pop", 0, 9'h000, 1, 0);
    for (int i = 0; i < 17; i++) step("sweep_fill", 1, 9'(9'h100 + i), 0, 0);
    for (int i = 0; i < 17; i++) step("sweep_drain", 0, 9'h000, 1, 0);

    for (int i = 0; i < 400; i++) begin
      bit         p;
      bit         r;
      bit         c;
      logic [8:0] d;
      p = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) < 10);
      d = 9'($urandom);
      step("rand", p, d, r, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rxfifo.md
# rxfifo

Parametrised receive FIFO for the USRT receive path, and the successor to the single-entry Rx data register. The deserialiser writes completed characters into the FIFO. The bus/register interface reads them out, with first-word-fall-through data, occupancy count, a programmable almost-full level and a sticky overrun flag. Everything runs in the `i_Pclk` domain.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: character width in bits (5..9 legal).
- `DEPTH`, default 4: number of entries; power of two, 2..64.
- `AFULL_LEVEL`, default `DEPTH-1`: `o_AlmostFull` asserts when count ≥ this value; legal range 1..DEPTH.

Ports:
- `i_Pclk` in 1: system clock; all state on rising edge.
- `i_Reset_n` in 1: reset; **one clock; reset is asynchronous and active-low**.
- `i_Push` in 1: write `i_Data` this cycle.
- `i_Data` in DATA_WIDTH: character from the deserialiser.
- `i_Pop` in 1: consume the head entry this cycle.
- `i_ClrOvr` in 1: clear the sticky overrun flag.
- `o_Data` out DATA_WIDTH: head entry; valid only while `o_Empty`=0.
- `o_Empty` out 1: no entries.
- `o_Full` out 1: count == DEPTH.
- `o_AlmostFull` out 1: count ≥ AFULL_LEVEL.
- `o_Count` out $clog2(DEPTH+1): current occupancy.
- `o_Overrun` out 1: sticky; a push was dropped because the FIFO was full.

## Operation
- Storage: DEPTH×DATA_WIDTH array plus write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits. Both wrap modulo DEPTH by natural overflow.
- Occupancy counter is DEPTH+1 states wide. Full/empty are derived from the counter, not from pointer comparison.
- Accepted push: `mem[wr_ptr]` ← `i_Data`, `wr_ptr`+1, count+1.
- Accepted pop: `rd_ptr`+1, count−1.
- Push acceptance: accepted if count < DEPTH, or if count == DEPTH and a pop is accepted in the same cycle.
- Dropped push: a push that is not accepted leaves memory, pointers and count unchanged and sets `o_Overrun`. Stored data is never overwritten.
- Pop acceptance: accepted only if count > 0. A pop on empty is ignored; no flag, no pointer move.
- Simultaneous push+pop with 0 < count < DEPTH: both accepted, count unchanged.
- Simultaneous push+pop with count == DEPTH: both accepted, count stays DEPTH, no overrun.
- Simultaneous push+pop with count == 0: push accepted, pop ignored, count becomes 1.
- Overrun clear: `i_ClrOvr` clears `o_Overrun`. If a dropped push occurs in the same cycle, set wins and `o_Overrun` stays 1.
- Memory contents are not reset. `o_Data` is don't-care while empty. The bench must not check `o_Data` while `o_Empty`=1.

## Timing
- Reset, asynchronous on the falling edge of `i_Reset_n`: pointers=0, count=0, `o_Empty`=1, `o_Full`=0, `o_AlmostFull`=0, `o_Count`=0, `o_Overrun`=0, `o_Data` don't-care.
- Reset deassertion is synchronised externally. A reset asserted mid-operation discards all contents immediately.
- Write-to-read latency is 1 cycle. A push at edge N makes `o_Empty`=0 and `o_Data`=pushed value after edge N.
- `o_Data` is a combinational read of `mem[rd_ptr]` (first-word-fall-through). It updates to the next entry the cycle after an accepted pop.
- All flags and `o_Count` are registered or decoded from registered count. They reflect state after the last edge; there is no same-cycle combinational path from `i_Push`/`i_Pop`.
- Wrap-around: after DEPTH accepted pushes `wr_ptr` returns to 0. Ordering is preserved across the wrap.

## Structure
- Shared package `usrt_pkg`: `RX_FIFO_DEPTH_DEFAULT`, the character-width constant, and a count-width helper function (`clog2` of DEPTH+1). The UART-side blocks use the same package.
- Natural sub-module: `rxfifo_mem`, a simple dual-port register array. Its ports are write enable, write address, write data, read address and asynchronous read data. It has no reset.
- The top level holds pointers, counter, flag logic and accept/drop decisions.

## Test plan
- Reset/idle: drive `i_Reset_n`=0 mid-cycle → outputs take reset values without waiting for a clock edge. Release, then one `i_Pop` → count stays 0, `o_Overrun`=0.
- Fill/drain, DEPTH=4: push 0x11, 0x22, 0x33, 0x44 → `o_Count`=4, `o_Full`=1, `o_AlmostFull` high from count 3. Then pop four times → `o_Data` shows 0x11, 0x22, 0x33, 0x44 in order, ending with `o_Empty`=1.
- Overrun: with FIFO full, push 0x55 → count stays 4, `o_Overrun`=1, contents unchanged. `i_ClrOvr` alone clears the flag. `i_ClrOvr` together with another dropped push → flag stays 1.
- Simultaneous events:
  - Full + push 0x66 + pop → no overrun, count 4, 0x66 is the last entry out.
  - Empty + push 0x77 + pop → count 1, `o_Data`=0x77.
- Wrap-around: 10 interleaved push/pop cycles with values 0x00..0x09 at count ≤ 2 → output sequence identical to input, pointers wrap with no loss.
- Parameter sweep: DEPTH=2 and DEPTH=16, DATA_WIDTH=9 → full/count/almost-full thresholds correct. Value 0x1FF passes through intact.
